// File: rtl/regfile_sequencer_if.sv
// Request/response handshake bundle between the decode logic (master)
// and the register-file sequencer (slave).
interface regfile_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_rd;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [DATA_W-1:0] req_imm;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_carry;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_carry
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, resp_ready,
    output req_ready, resp_valid, resp_data, resp_carry
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle initiator for the 4x8 register file: read operands, execute,
// write back once, then hand the result out over a valid/ready response.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_sequencer_if.slave bus,
  output logic [ADDR_W-1:0] rs1_addr_o,
  output logic [ADDR_W-1:0] rs2_addr_o,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              reg_wr_en_o
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_LI   = 3'b101,
    OP_MOV  = 3'b110,
    OP_READ = 3'b111
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   res_q, res_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W:0]   alu;

  // Top bit of the 9-bit result is carry for ADD and borrow for SUB.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu = {1'b0, a_q & b_q};
      OP_OR:   alu = {1'b0, a_q | b_q};
      OP_XOR:  alu = {1'b0, a_q ^ b_q};
      OP_LI:   alu = {1'b0, imm_q};
      default: alu = {1'b0, a_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d       = op_e'(bus.req_op);
          rd_d       = bus.req_rd;
          rs1_addr_d = bus.req_rs1;
          rs2_addr_d = bus.req_rs2;
          imm_d      = bus.req_imm;
          state_d    = READ;
        end
      end
      READ: begin
        a_d     = rs1_data_i;
        b_d     = rs2_data_i;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu;
        state_d = WB;
        // Write strobe is registered so it is high for exactly the WB cycle.
        if (op_q != OP_READ) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_q;
          wr_data_d = alu[DATA_W-1:0];
        end
      end
      WB: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = res_q[DATA_W-1:0];
  assign bus.resp_carry = res_q[DATA_W];
  assign rs1_addr_o     = rs1_addr_q;
  assign rs2_addr_o     = rs2_addr_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign reg_wr_en_o    = wr_en_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a bench-side register file, a cycle-level
// reference model checked every cycle, and directed operations with literal results.
module tb_regfile_sequencer;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic checkEn = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk = ~clk;

  regfile_sequencer_if bus ();

  logic [1:0] rs1Addr, rs2Addr, wrAddr;
  logic [7:0] rs1Data, rs2Data, wrData;
  logic       regWrEn;
  logic [7:0] rf [4] = '{default: 8'h00};

  assign rs1Data = rf[rs1Addr];
  assign rs2Data = rf[rs2Addr];

  always @(posedge clk) begin
    if (regWrEn === 1'b1) rf[wrAddr] <= wrData;
  end

  regfile_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rs1_addr_o (rs1Addr),
    .rs2_addr_o (rs2Addr),
    .rs1_data_i (rs1Data),
    .rs2_data_i (rs2Data),
    .wr_addr_o  (wrAddr),
    .wr_data_o  (wrData),
    .reg_wr_en_o(regWrEn)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] refOp(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] imm);
    int s;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        return {1'(s > 255), 8'(s % 256)};
      end
      3'd1: begin
        s = (int'(a) - int'(b) + 256) % 256;
        return {1'(a < b), 8'(s)};
      end
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, imm};
      default: return {1'b0, a};
    endcase
  endfunction

  // Reference model: phase counts cycles since acceptance (0 = waiting for a request).
  int         phase = 0;
  logic [2:0] mOp   = '0;
  logic [1:0] mRd   = '0;
  logic [1:0] mRs1  = '0;
  logic [1:0] mRs2  = '0;
  logic [8:0] mRes  = '0;
  logic [7:0] mrf [4] = '{default: 8'h00};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (bus.req_valid === 1'b1) begin
        mOp   <= bus.req_op;
        mRd   <= bus.req_rd;
        mRs1  <= bus.req_rs1;
        mRs2  <= bus.req_rs2;
        mRes  <= refOp(bus.req_op, mrf[bus.req_rs1], mrf[bus.req_rs2], bus.req_imm);
        phase <= 1;
      end
    end else if (phase < 4) begin
      if (phase == 3 && mOp != 3'b111) mrf[mRd] <= mRes[7:0];
      phase <= phase + 1;
    end else if (bus.resp_ready === 1'b1) begin
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("req_ready", bus.req_ready, phase == 0);
      check("reg_wr_en", regWrEn, (phase == 3) && (mOp != 3'b111));
      if (phase == 3 && mOp != 3'b111) begin
        check("wr_addr", wrAddr, mRd);
        check("wr_data", wrData, mRes[7:0]);
      end
      check("resp_valid", bus.resp_valid, phase == 4);
      if (phase == 4) begin
        check("resp_data", bus.resp_data, mRes[7:0]);
        check("resp_carry", bus.resp_carry, mRes[8]);
      end
      if (phase == 1) begin
        check("rs1_addr", rs1Addr, mRs1);
        check("rs2_addr", rs2Addr, mRs2);
      end
    end
  end

  int         obsWait, obsWrCount, obsWrCycle, obsRespCycle, obsUnstable;
  logic [1:0] obsWrAddr, obsRs1, obsRs2;
  logic [7:0] obsWrData, obsData;
  logic       obsCarry, obsStallReady;

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                               input logic [1:0] rs2, input logic [7:0] imm, input int stall,
                               input bit holdValid);
    int k;
    bit done;
    @(negedge clk);
    bus.req_op     = op;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b0;
    obsWait = 0;
    while (bus.req_ready !== 1'b1 && obsWait < 20) begin
      @(negedge clk);
      obsWait++;
    end
    check("accept_in_time", obsWait < 20, 1'b1);
    if (obsWait >= 20) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    obsWrCount = 0; obsWrCycle = -1; obsRespCycle = -1; obsUnstable = 0;
    obsStallReady = 1'b0; done = 1'b0; k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!holdValid) bus.req_valid = 1'b0;
        obsRs1 = rs1Addr;
        obsRs2 = rs2Addr;
      end
      if (regWrEn === 1'b1) begin
        obsWrCount++;
        obsWrCycle = k;
        obsWrAddr  = wrAddr;
        obsWrData  = wrData;
      end
      if (bus.resp_valid === 1'b1) begin
        if (obsRespCycle < 0) begin
          obsRespCycle = k;
          obsData      = bus.resp_data;
          obsCarry     = bus.resp_carry;
        end else if (bus.resp_data !== obsData || bus.resp_carry !== obsCarry) begin
          obsUnstable++;
        end
        if (stall > 0) begin
          bus.resp_ready = 1'b0;
          obsStallReady  = obsStallReady | bus.req_ready;
          stall--;
        end else begin
          bus.resp_ready = 1'b1;
          @(posedge clk);
          done = 1'b1;
        end
      end
    end
    check("response_in_time", done, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expData, input logic expCarry,
                             input int expWrites, input logic [1:0] expWrAddr);
    check({tag, " resp_cycle"}, obsRespCycle, 4);
    check({tag, " resp_data"}, obsData, expData);
    check({tag, " resp_carry"}, obsCarry, expCarry);
    check({tag, " write_count"}, obsWrCount, expWrites);
    if (expWrites != 0) begin
      check({tag, " wr_cycle"}, obsWrCycle, 3);
      check({tag, " wr_addr"}, obsWrAddr, expWrAddr);
      check({tag, " wr_data"}, obsWrData, expData);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int pulses;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_rd     = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_imm    = '0;
    bus.resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    checkEn = 1'b1;
    #12;
    check("rst req_ready", bus.req_ready, 1'b1);
    check("rst reg_wr_en", regWrEn, 1'b0);
    check("rst resp_valid", bus.resp_valid, 1'b0);
    check("rst resp_data", bus.resp_data, 8'h00);
    check("rst resp_carry", bus.resp_carry, 1'b0);
    check("rst rs1_addr", rs1Addr, 2'd0);
    check("rst rs2_addr", rs2Addr, 2'd0);
    check("rst wr_addr", wrAddr, 2'd0);
    check("rst wr_data", wrData, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'b101, 2'd1, 2'd0, 2'd0, 8'h3C, 0, 1'b0);
    checkOutput("li_r1", 8'h3C, 1'b0, 1, 2'd1);
    applyStimulus(3'b101, 2'd2, 2'd0, 2'd0, 8'hC5, 0, 1'b0);
    checkOutput("li_r2", 8'hC5, 1'b0, 1, 2'd2);
    applyStimulus(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    checkOutput("add", 8'h01, 1'b1, 1, 2'd3);
    check("add read rs1_addr", obsRs1, 2'd1);
    check("add read rs2_addr", obsRs2, 2'd2);
    applyStimulus(3'b001, 2'd0, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    checkOutput("sub_borrow", 8'h77, 1'b1, 1, 2'd0);
    applyStimulus(3'b001, 2'd0, 2'd2, 2'd1, 8'h00, 0, 1'b0);
    checkOutput("sub", 8'h89, 1'b0, 1, 2'd0);
    applyStimulus(3'b100, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1'b0);
    checkOutput("xor_self", 8'h00, 1'b0, 1, 2'd1);
    applyStimulus(3'b111, 2'd2, 2'd3, 2'd3, 8'h00, 0, 1'b0);
    checkOutput("read_r3", 8'h01, 1'b0, 0, 2'd2);

    // Backpressure with the next request already pending on the port.
    applyStimulus(3'b011, 2'd1, 2'd3, 2'd0, 8'h00, 3, 1'b1);
    checkOutput("or_stall", 8'h89, 1'b0, 1, 2'd1);
    check("stall resp stable", obsUnstable, 0);
    check("stall req_ready", obsStallReady, 1'b0);
    applyStimulus(3'b011, 2'd1, 2'd3, 2'd0, 8'h00, 0, 1'b0);
    check("held req wait", obsWait, 0);
    checkOutput("or_again", 8'h89, 1'b0, 1, 2'd1);

    // Abandon ADD r0,r1,r2 (would write 0x4E) by resetting during EXEC.
    @(negedge clk);
    bus.req_op = 3'b000; bus.req_rd = 2'd0; bus.req_rs1 = 2'd1; bus.req_rs2 = 2'd2;
    bus.req_valid = 1'b1;
    bus.resp_ready = 1'b0;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("reset op accepted", w < 20, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst req_ready", bus.req_ready, 1'b1);
    check("midrst reg_wr_en", regWrEn, 1'b0);
    check("midrst resp_valid", bus.resp_valid, 1'b0);
    check("midrst resp_data", bus.resp_data, 8'h00);
    check("midrst resp_carry", bus.resp_carry, 1'b0);
    check("midrst rs1_addr", rs1Addr, 2'd0);
    check("midrst rs2_addr", rs2Addr, 2'd0);
    check("midrst wr_addr", wrAddr, 2'd0);
    check("midrst wr_data", wrData, 8'h00);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (regWrEn !== 1'b0) pulses++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset req_ready", bus.req_ready, 1'b1);
    repeat (5) begin
      @(negedge clk);
      if (regWrEn !== 1'b0) pulses++;
    end
    check("abandoned op write pulses", pulses, 0);
    applyStimulus(3'b111, 2'd0, 2'd0, 2'd0, 8'h00, 0, 1'b0);
    checkOutput("read_r0_after_reset", 8'h89, 1'b0, 0, 2'd0);

    repeat (2) @(negedge clk);
    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle initiator for the 4x8-bit register file. It accepts one register-level operation at a time over a valid/ready request port. It drives the register file's two read-address ports, captures the operands, computes the result, and issues a single-cycle write-back on the write port. It then returns the result over a valid/ready response port. It sits between the control/decode logic and the register file, and is the only agent driving the register file's address, write-data and write-enable inputs.

## Interface
- DATA_W, 8, datapath width (register width)
- ADDR_W, 2, register address width (4 registers)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low (0 = reset asserted)
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LI, 110 MOV, 111 READ
- req_rd  in  ADDR_W  destination register
- req_rs1, req_rs2  in  ADDR_W  source registers
- req_imm  in  DATA_W  immediate (LI only)
- rs1_addr, rs2_addr  out  ADDR_W  to register file read ports
- rs1_data, rs2_data  in  DATA_W  combinational read data from register file
- wr_addr  out  ADDR_W  to register file write address
- wr_data  out  DATA_W  to register file write data
- reg_wr_en  out  1  register file write enable
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  DATA_W  operation result
- resp_carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops

## Operation
- FSM states: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE. No other transitions except reset.
- IDLE:
  - req_ready=1.
  - Handshake (req_valid & req_ready) latches op, rd, rs1, rs2 and imm, then goes to READ.
  - Request inputs are ignored in every other state.
- READ:
  - rs1_addr and rs2_addr are driven from the latched fields (registered; stable for the whole cycle).
  - rs1_data and rs2_data are captured into operand registers at the end of the cycle.
- EXEC: computes a 9-bit intermediate result, registered at the end of the cycle.
  - ADD: {carry, r} = a + b.
  - SUB: r = (a - b) mod 2^DATA_W; carry = (a < b) unsigned.
  - AND, OR, XOR: bitwise; carry = 0.
  - LI: r = imm.
  - MOV and READ: r = a.
- WB:
  - For ops 000-110: reg_wr_en=1 for exactly this cycle, wr_addr=rd, wr_data=r.
  - For op 111 (READ): reg_wr_en stays 0.
- RESP:
  - resp_valid=1; resp_data and resp_carry hold the result.
  - Leaves on resp_valid & resp_ready.
  - Holds with all outputs stable while resp_ready=0.
- Overlapping registers:
  - rs1==rs2 is legal.
  - rd equal to a source is legal: operands are captured before the write.
  - A following request that reads the just-written register sees the new value.
- wr_addr and wr_data keep their last values outside WB. They are meaningful only while reg_wr_en=1.

## Timing
- Cycle 0 = request handshake edge. READ is cycle 1, EXEC is cycle 2, WB is cycle 3 (reg_wr_en high; register file updates at the end of cycle 3), and RESP starts in cycle 4.
- resp_valid first rises 4 cycles after acceptance.
- Minimum 5 cycles per operation (resp_ready held high). The next req_ready is in the cycle after the response handshake.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Reset values (applied asynchronously on reset=0):
  - state=IDLE, req_ready=1.
  - rs1_addr=0, rs2_addr=0, wr_addr=0, wr_data=0, reg_wr_en=0.
  - resp_valid=0, resp_data=0, resp_carry=0.
  - Operand and result registers are 0.
- Reset asserted mid-operation:
  - The operation is abandoned and reg_wr_en drops immediately.
  - No write and no response are ever produced for it.
  - After release, the block is in IDLE with req_ready=1 on the first edge.
- reg_wr_en is never high while reset=0.

## Test plan
- Reset, then LI r1,0x3C and LI r2,0xC5 -> each: reg_wr_en high exactly 1 cycle, 3 cycles after acceptance, with wr_addr=1/wr_data=0x3C (then 2/0xC5); resp_data matches; resp_carry=0.
- ADD r3,r1,r2 -> in READ rs1_addr=1, rs2_addr=2; WB writes r3=0x01; resp_data=0x01, resp_carry=1, resp_valid 4 cycles after acceptance.
- SUB r0,r1,r2 -> r0=0x77, resp_carry=1. Then SUB r0,r2,r1 -> 0x89, resp_carry=0. Then XOR r1,r1,r1 -> 0x00, resp_carry=0.
- READ on rs1=r3 -> resp_data=0x01; reg_wr_en stays 0 for the whole operation.
- Backpressure: hold resp_ready=0 for 3 cycles in RESP while driving req_valid=1 -> resp_valid, resp_data and resp_carry stay stable; req_ready=0; the request is not accepted until the cycle after the response handshake.
- Drive reset=0 during EXEC of ADD r0,r1,r2 -> all outputs take reset values immediately and reg_wr_en never pulses. After release, req_ready=1. A READ of r0 returns its pre-reset value (the register file is not reset by this bench).
